// File: rtl/axi4lite_apb_bridge.sv
`default_nettype none
// axi4lite_apb_bridge: AXI4-Lite slave to APB master bridge, one outstanding
// transaction, write/read fair arbitration on simultaneous requests.
module axi4lite_apb_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;
  logic   last_rd;
  logic   wr_elig;
  logic   rd_elig;
  logic   grant_wr;
  logic   grant_rd;

  // On a tie the type that did not win last time is granted.
  always_comb begin
    wr_elig  = s_awvalid && s_wvalid;
    rd_elig  = s_arvalid;
    grant_wr = (state == IDLE) && wr_elig && (!rd_elig || last_rd);
    grant_rd = (state == IDLE) && rd_elig && (!wr_elig || !last_rd);
  end

  // Readies are combinational but must stay low while reset is held.
  assign s_awready = reset_n && grant_wr;
  assign s_wready  = reset_n && grant_wr;
  assign s_arready = reset_n && grant_rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_rd  <= 1'b1;
      paddr    <= '0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      s_bvalid <= 1'b0;
      s_bresp  <= 2'b00;
      s_rvalid <= 1'b0;
      s_rresp  <= 2'b00;
      s_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            paddr   <= grant_wr ? s_awaddr : s_araddr;
            pwrite  <= grant_wr;
            if (grant_wr) pwdata <= s_wdata;
            last_rd <= grant_rd;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pwrite) begin
              s_bvalid <= 1'b1;
              s_bresp  <= pslverr ? 2'b10 : 2'b00;
            end else begin
              s_rvalid <= 1'b1;
              s_rresp  <= pslverr ? 2'b10 : 2'b00;
              s_rdata  <= prdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) begin
            s_bvalid <= 1'b0;
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/axi4lite_apb_bridge.md
AXI4LITE_APB_BRIDGE -- requirements
Module: axi4lite_apb_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the AXI and APB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the AXI and APB data width.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have the AXI4-Lite write address ports s_awaddr (input, ADDR_WIDTH), s_awvalid (input, 1) and s_awready (output, 1).
REQ-006 The block SHALL have the AXI4-Lite write data ports s_wdata (input, DATA_WIDTH), s_wvalid (input, 1) and s_wready (output, 1).
REQ-007 The block SHALL have the AXI4-Lite write response ports s_bresp (output, 2), s_bvalid (output, 1) and s_bready (input, 1).
REQ-008 The block SHALL have the AXI4-Lite read address ports s_araddr (input, ADDR_WIDTH), s_arvalid (input, 1) and s_arready (output, 1).
REQ-009 The block SHALL have the AXI4-Lite read data ports s_rdata (output, DATA_WIDTH), s_rresp (output, 2), s_rvalid (output, 1) and s_rready (input, 1).
REQ-010 The block SHALL have the APB master request ports paddr (output, ADDR_WIDTH), pwrite (output, 1) and pwdata (output, DATA_WIDTH).
REQ-011 The block SHALL have the APB master phase ports psel (output, 1) and penable (output, 1).
REQ-012 The block SHALL have the APB completion ports prdata (input, DATA_WIDTH), pready (input, 1) and pslverr (input, 1); pslverr is tied 0 when the slave has no error output.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESP, and SHALL allow one outstanding transaction only.
REQ-014 In IDLE, a write SHALL be eligible only when s_awvalid and s_wvalid are both 1; an AW without W (or W without AW) SHALL NOT be accepted.
REQ-015 In IDLE, a read SHALL be eligible when s_arvalid is 1.
REQ-016 When both are eligible, the block SHALL grant the type not granted last (last-grant flag); reset sets the flag to read, so the first tie goes to write.
REQ-017 On a grant, the ready(s) of the granted channel(s) SHALL be 1 combinationally in that IDLE cycle; the block SHALL latch the address, data and direction, and move to SETUP.
REQ-018 s_awready, s_wready and s_arready SHALL be 0 in every state except IDLE, and 0 for the non-granted channel.
REQ-019 In SETUP, psel SHALL be 1 and penable 0, with paddr, pwrite and pwdata driven from the latched values; the next state SHALL be ACCESS.
REQ-020 In ACCESS, psel and penable SHALL be 1 and all request signals SHALL be held stable until pready is 1, with no timeout.
REQ-021 On ACCESS with pready=1, the block SHALL capture prdata into s_rdata for reads and pslverr for both types, and move to RESP.
REQ-022 psel and penable SHALL both be 0 from the RESP cycle onward.
REQ-023 In RESP, the block SHALL assert s_bvalid (write) or s_rvalid (read), with resp = 2'b10 if the captured pslverr is 1, else 2'b00.
REQ-024 RESP SHALL be held, with s_rdata stable, until s_bready or s_rready is 1, after which the next state SHALL be IDLE.
REQ-025 Minimum latency with zero-wait APB and a ready master SHALL be: handshake at cycle T, SETUP T+1, ACCESS T+2, response valid T+3, and a next handshake possible at T+4.
REQ-026 paddr SHALL equal the full captured AXI address, with no translation and no alignment check.
REQ-027 AXI valid inputs asserted during SETUP, ACCESS or RESP SHALL be ignored until IDLE.

Reset
REQ-028 While reset_n is 0, all outputs SHALL be 0, the state SHALL be IDLE and the last-grant flag SHALL be read.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction immediately: psel and penable drop asynchronously and no response is issued.

Verification
REQ-030 The bench SHALL cover a write of 0x000000A5 to 0x0000 with pready=1: psel rises at T+1, penable at T+2, and s_bvalid is 1 with bresp=00 at T+3.
REQ-031 The bench SHALL cover a read of 0x0008 with prdata=0x3C and pready=1: s_rvalid at T+3 with s_rdata=0x0000003C and rresp=00.
REQ-032 The bench SHALL cover pready held 0 for 3 ACCESS cycles: penable stays 1 for 4 cycles, paddr and pwdata stay stable, and the response follows one cycle later.
REQ-033 The bench SHALL cover simultaneous write and read valid after reset: the write is granted first, then the read; with both held, grants alternate.
REQ-034 The bench SHALL cover pslverr=1 on a read: rresp=10; and s_rready held 0 for 5 cycles: s_rvalid and s_rdata hold and no new handshake occurs.
REQ-035 The bench SHALL cover s_awvalid=1 with s_wvalid=0 for 3 cycles: no psel; then s_wvalid=1: both readies pulse in the same cycle.
